// File: rtl/fetch_buf_if.sv
// Handshake bundle between instruction memory response, fetch control and decode.
// master = fetch/memory/decode side, slave = the buffer itself.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

interface fetch_buf_if #(
    parameter int ADDR_W  = `ADDR_WIDTH,
    parameter int INSTR_W = `INSTR_WIDTH
);
    logic [INSTR_W-1:0] instr_read_data;
    logic               instr_read_data_valid;
    logic [ADDR_W-1:0]  pc;
    logic               flush;
    logic               fetch_stall;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;
    logic               dec_valid;
    logic               dec_ready;
    logic               buf_ovf;

    modport master (
        output instr_read_data, instr_read_data_valid, pc, flush, dec_ready,
        input  fetch_stall, dec_instr, dec_pc, dec_valid, buf_ovf
    );

    modport slave (
        input  instr_read_data, instr_read_data_valid, pc, flush, dec_ready,
        output fetch_stall, dec_instr, dec_pc, dec_valid, buf_ovf
    );
endinterface

// File: rtl/fetch_buf.sv
// Circular instruction buffer between the instruction memory response and decode.
// Keeps one slot spare for the single in-flight response via a registered fetch_stall.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module fetch_buf #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = `ADDR_WIDTH,
    parameter int INSTR_W = `INSTR_WIDTH
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    fetch_buf_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(DEPTH - 1);

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fetch_stall_q, fetch_stall_d;
    logic             buf_ovf_q, buf_ovf_d;
    logic             dec_valid;
    logic             push, pop;

    assign dec_valid = (count_q != '0);

    always_comb begin
        pop  = dec_valid & bus.dec_ready & ~bus.flush;
        push = bus.instr_read_data_valid & ~bus.flush & ((count_q != FULL) | pop);

        wr_ptr_d      = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d       = count_q;
        buf_ovf_d     = buf_ovf_q;
        fetch_stall_d = 1'b0;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A response that finds the buffer full with nothing leaving is lost.
        if (bus.instr_read_data_valid && !bus.flush && count_q == FULL && !pop)
            buf_ovf_d = 1'b1;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        fetch_stall_d = (count_d >= STALL_AT);
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            fetch_stall_q <= 1'b0;
            buf_ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fetch_stall_q <= fetch_stall_d;
            buf_ovf_q     <= buf_ovf_d;
        end
    end

    // Storage carries no reset; dec_valid qualifies whatever it holds.
    always_ff @(posedge cpu_clk) begin
        if (push && !cpu_rst) begin
            instr_mem[wr_ptr_q] <= bus.instr_read_data;
            pc_mem[wr_ptr_q]    <= bus.pc;
        end
    end

    assign bus.dec_valid   = dec_valid;
    assign bus.dec_instr   = instr_mem[rd_ptr_q];
    assign bus.dec_pc      = pc_mem[rd_ptr_q];
    assign bus.fetch_stall = fetch_stall_q;
    assign bus.buf_ovf     = buf_ovf_q;
endmodule

// File: tb/tb_fetch_buf.sv
// Directed scenarios followed by random traffic, checked every cycle against a
// queue-based model of the buffer.
module tb_fetch_buf;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_buf_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

    fetch_buf #(.DEPTH(DEPTH), .ADDR_W(32), .INSTR_W(32)) dut (
        .cpu_clk (clk),
        .cpu_rst (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      q[$];
    bit          m_ovf   = 1'b0;
    bit          m_stall = 1'b0;
    logic [31:0] popped[$];
    int          compared   = 0;
    int          mismatched = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("dec_valid", {63'd0, bus.dec_valid}, {63'd0, q.size() != 0});
        chk("fetch_stall", {63'd0, bus.fetch_stall}, {63'd0, m_stall});
        chk("buf_ovf", {63'd0, bus.buf_ovf}, {63'd0, m_ovf});
        if (q.size() != 0) begin
            chk("dec_pc", {32'd0, bus.dec_pc}, {32'd0, q[0].pc});
            chk("dec_instr", {32'd0, bus.dec_instr}, {32'd0, q[0].instr});
        end
    endtask

    // One clock of stimulus, model update and check.
    task automatic step(input bit v, input logic [31:0] p, input bit rdy, input bit fl, input bit r);
        entry_t e;
        bit     do_pop;
        bit     room;
        e.instr = $urandom;
        e.pc    = p;
        rst                       = r;
        bus.instr_read_data_valid = v;
        bus.instr_read_data       = e.instr;
        bus.pc                    = p;
        bus.dec_ready             = rdy;
        bus.flush                 = fl;
        if (bus.dec_valid && rdy && !fl && !r)
            popped.push_back(bus.dec_pc);
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            m_ovf   = 1'b0;
            m_stall = 1'b0;
        end else if (fl) begin
            q.delete();
            m_stall = 1'b0;
        end else begin
            do_pop = (q.size() != 0) && rdy;
            room   = (q.size() < DEPTH) || do_pop;
            if (do_pop) q.delete(0);
            if (v && room) q.push_back(e);
            else if (v) m_ovf = 1'b1;
            m_stall = (q.size() >= DEPTH - 1);
        end
        check_model();
    endtask

    initial begin
        bus.instr_read_data_valid = 1'b0;
        bus.instr_read_data       = '0;
        bus.pc                    = '0;
        bus.dec_ready             = 1'b0;
        bus.flush                 = 1'b0;

        // Reset state
        step(0, 32'h0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 1);
        chk("rst_valid", {63'd0, bus.dec_valid}, 64'd0);
        chk("rst_ovf", {63'd0, bus.buf_ovf}, 64'd0);

        // Fill three entries with decode stalled
        step(1, 32'h00, 0, 0, 0);
        step(1, 32'h04, 0, 0, 0);
        step(1, 32'h08, 0, 0, 0);
        chk("fill_stall", {63'd0, bus.fetch_stall}, 64'd1);
        chk("fill_head", {32'd0, bus.dec_pc}, 64'h00);

        // Reach full, then push and pop together at full
        step(1, 32'h0C, 0, 0, 0);
        step(1, 32'h10, 1, 0, 0);
        chk("full_pp_head", {32'd0, bus.dec_pc}, 64'h04);
        chk("full_pp_ovf", {63'd0, bus.buf_ovf}, 64'd0);

        // Overflow is sticky
        step(1, 32'h14, 0, 0, 0);
        chk("ovf_set", {63'd0, bus.buf_ovf}, 64'd1);
        step(0, 32'h0, 0, 0, 0);

        // Drop to three entries, then flush with a valid response
        step(0, 32'h0, 1, 0, 0);
        step(1, 32'h20, 0, 1, 0);
        chk("flush_valid", {63'd0, bus.dec_valid}, 64'd0);
        chk("flush_stall", {63'd0, bus.fetch_stall}, 64'd0);
        step(1, 32'h80, 0, 0, 0);
        chk("post_flush_pc", {32'd0, bus.dec_pc}, 64'h80);
        chk("ovf_sticky", {63'd0, bus.buf_ovf}, 64'd1);

        // Streaming through pointer wrap
        step(0, 32'h0, 0, 0, 1);
        popped.delete();
        for (int i = 0; i < 10; i++) step(1, 32'(i * 4), 1, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 1, 0, 0);
        chk("wrap_count", 64'(popped.size()), 64'd10);
        for (int i = 0; i < 10 && i < popped.size(); i++)
            chk("wrap_order", {32'd0, popped[i]}, 64'(i * 4));

        // Reset in the middle of a stream
        step(1, 32'h100, 0, 0, 0);
        step(1, 32'h104, 0, 0, 0);
        step(0, 32'h0, 0, 0, 1);
        chk("midrst_valid", {63'd0, bus.dec_valid}, 64'd0);
        step(1, 32'h200, 0, 0, 0);
        chk("midrst_first", {32'd0, bus.dec_pc}, 64'h200);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fetch_buf.md
FETCH_BUF -- requirements
Module: fetch_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of instruction entries; power of two, >= 2.
REQ-002 SHALL have parameter ADDR_W, default `ADDR_WIDTH (32), width of pc fields.
REQ-003 SHALL have parameter INSTR_W, default `INSTR_WIDTH (32), width of instruction fields.
REQ-004 cpu_clk  input  1  cpu clock; all state updates on rising edge.
REQ-005 cpu_rst  input  1  reset, synchronous, active-high.
REQ-006 instr_read_data  input  INSTR_W  instruction returned by the instruction memory controller.
REQ-007 instr_read_data_valid  input  1  instr_read_data is valid this cycle.
REQ-008 pc  input  ADDR_W  address of the instruction returned this cycle.
REQ-009 flush  input  1  branch/trap redirect; discard all buffered and arriving instructions.
REQ-010 fetch_stall  output  1  tells fetch to hold next_pc; no new request may be issued.
REQ-011 dec_instr  output  INSTR_W  head-entry instruction to decode.
REQ-012 dec_pc  output  ADDR_W  head-entry pc to decode.
REQ-013 dec_valid  output  1  head entry valid.
REQ-014 dec_ready  input  1  decode accepts head entry this cycle.
REQ-015 buf_ovf  output  1  sticky error: valid data arrived with no free slot.

Function
REQ-016 SHALL implement a circular FIFO of DEPTH entries {instr, pc}, wr_ptr/rd_ptr of log2(DEPTH) bits wrapping DEPTH-1 -> 0, count of log2(DEPTH)+1 bits.
REQ-017 pop SHALL = dec_valid & dec_ready & ~flush; rd_ptr +1, head advances next cycle.
REQ-018 push SHALL = instr_read_data_valid & ~flush & (count < DEPTH | pop); writes {instr_read_data, pc} at wr_ptr, wr_ptr +1.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, including at count = DEPTH and count = 0 is excluded (pop needs dec_valid).
REQ-020 count SHALL update as count + push - pop; never exceeds DEPTH, never underflows.
REQ-021 dec_valid SHALL = (count != 0); dec_instr/dec_pc SHALL be the entry at rd_ptr, driven from registers; data pushed in cycle N visible on decode at cycle N+1 earliest (no bypass).
REQ-022 dec_instr/dec_pc SHALL hold stable while dec_valid & ~dec_ready (no flush).
REQ-023 fetch_stall SHALL = (count + push - pop) >= DEPTH-1, registered, so one slot always remains for the single in-flight 1-cycle-latency response.
REQ-024 flush SHALL, next cycle, force count=0, wr_ptr=rd_ptr=0, dec_valid=0, fetch_stall=0; data valid in the flush cycle SHALL be discarded; flush overrides push and pop.
REQ-025 instr_read_data_valid with count = DEPTH, no pop, no flush SHALL drop the data and set buf_ovf; buf_ovf stays 1 until cpu_rst.
REQ-026 Storage array contents SHALL NOT require reset; only control state and outputs are reset.

Reset
REQ-027 While cpu_rst=1 at a rising edge: count=0, wr_ptr=rd_ptr=0, dec_valid=0, fetch_stall=0, buf_ovf=0; dec_instr/dec_pc undefined-content but dec_valid gates them.
REQ-028 cpu_rst mid-operation SHALL discard all entries; first push after deassertion appears on decode one cycle later.
REQ-029 cpu_rst SHALL take priority over flush, push and pop.

Verification
REQ-030 Fill: dec_ready=0, valid responses pc=0x00,0x04,0x08 -> count=3, fetch_stall=1 after third push (DEPTH=4), dec_pc=0x00 held.
REQ-031 Full + simultaneous: count=4, dec_ready=1 and valid pc=0x10 same cycle -> pc=0x00 popped, 0x10 stored, count stays 4, buf_ovf=0.
REQ-032 Overflow: count=4, dec_ready=0, valid pc=0x14 -> data dropped, buf_ovf=1 next cycle and sticky until cpu_rst.
REQ-033 Flush: count=3, flush=1 with valid pc=0x20 -> next cycle count=0, dec_valid=0, fetch_stall=0, 0x20 not stored; pc=0x80 next cycle appears on dec_pc one cycle later.
REQ-034 Wrap: stream 10 instructions pc=0x00..0x24 with dec_ready=1 every cycle -> dec_pc sequence exact, in order, one-cycle latency, no stall, pointers wrap.
REQ-035 Reset mid-stream: count=2, cpu_rst=1 one cycle -> dec_valid=0, count=0, buf_ovf=0 next cycle.
